// File: rtl/video_sync_gen.sv
// rtl/video_sync_gen.sv - composite sync, burst gate and synthetic target generator
module video_sync_gen #(
  parameter int unsigned LINE_CLKS    = 254,
  parameter int unsigned HSYNC_CLKS   = 19,
  parameter int unsigned BURST_START  = 21,
  parameter int unsigned BURST_CLKS   = 10,
  parameter int unsigned FIELD0_LINES = 263,
  parameter int unsigned FIELD1_LINES = 262,
  parameter int unsigned VSYNC_LINES  = 9,
  parameter int unsigned TGT_W        = 4,
  parameter int unsigned TGT_H        = 4
) (
  input  logic       clk4mhz,
  input  logic       reset,
  input  logic       tgt_en,
  input  logic [8:0] tgt_line,
  input  logic [8:0] tgt_col,
  output logic       csync,
  output logic       vsync,
  output logic       field,
  output logic       burst,
  output logic       target,
  output logic       line_start,
  output logic       field_start
);

  localparam logic [7:0] HLAST  = 8'(LINE_CLKS - 1);
  localparam logic [8:0] VLAST0 = 9'(FIELD0_LINES - 1);
  localparam logic [8:0] VLAST1 = 9'(FIELD1_LINES - 1);
  localparam logic [9:0] HS_10  = 10'(HSYNC_CLKS);
  localparam logic [9:0] BS_10  = 10'(BURST_START);
  localparam logic [9:0] BE_10  = 10'(BURST_START + BURST_CLKS);
  localparam logic [9:0] VS_10  = 10'(VSYNC_LINES);
  localparam logic [9:0] TW_10  = 10'(TGT_W);
  localparam logic [9:0] TH_10  = 10'(TGT_H);

  // Timing state
  logic [7:0] hcnt_q, hcnt_d;
  logic [8:0] vcnt_q, vcnt_d;
  logic       field_q, field_d;

  // Target box, frozen for the duration of a field
  logic       sh_en_q;
  logic [8:0] sh_line_q;
  logic [8:0] sh_col_q;

  // Registered outputs
  logic csync_q, vsync_q, field_out_q, burst_q, target_q, line_start_q, field_start_q;

  // Decodes of the current state
  logic       h_wrap, v_wrap, at_origin;
  logic       csync_d, vsync_d, burst_d, target_d, line_start_d, field_start_d;
  logic       line_hit, col_hit;
  logic [9:0] hcnt_w, vcnt_w, acol, aline, line_lo, col_lo;

  // Next counter state: advance hcnt, step vcnt at line end, flip field at field end
  always_comb begin
    h_wrap = (hcnt_q == HLAST);
    v_wrap = field_q ? (vcnt_q == VLAST1) : (vcnt_q == VLAST0);
    hcnt_d = h_wrap ? 8'd0 : hcnt_q + 8'd1;
    vcnt_d = vcnt_q;
    field_d = field_q;
    if (h_wrap) begin
      if (v_wrap) begin
        vcnt_d  = 9'd0;
        field_d = ~field_q;
      end else begin
        vcnt_d = vcnt_q + 9'd1;
      end
    end
  end

  // Output decodes of the current counter state, widened to 10 bits so box edges clip
  always_comb begin
    hcnt_w        = {2'b00, hcnt_q};
    vcnt_w        = {1'b0, vcnt_q};
    acol          = hcnt_w - HS_10;
    aline         = vcnt_w - VS_10;
    line_lo       = {1'b0, sh_line_q};
    col_lo        = {1'b0, sh_col_q};
    at_origin     = (hcnt_q == 8'd0) && (vcnt_q == 9'd0);
    csync_d       = (hcnt_w < HS_10);
    vsync_d       = (vcnt_w < VS_10);
    burst_d       = !vsync_d && (hcnt_w >= BS_10) && (hcnt_w < BE_10);
    line_hit      = (aline >= line_lo) && (aline < line_lo + TH_10);
    col_hit       = (acol >= col_lo) && (acol < col_lo + TW_10);
    target_d      = sh_en_q && !csync_d && !vsync_d && line_hit && col_hit;
    line_start_d  = (hcnt_q == 8'd0);
    field_start_d = at_origin;
  end

  // Counters, field-start shadow load of the target box, and registered outputs
  always_ff @(posedge clk4mhz) begin
    if (reset) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      field_q       <= 1'b0;
      sh_en_q       <= 1'b0;
      sh_line_q     <= '0;
      sh_col_q      <= '0;
      csync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      field_out_q   <= 1'b0;
      burst_q       <= 1'b0;
      target_q      <= 1'b0;
      line_start_q  <= 1'b0;
      field_start_q <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      field_q <= field_d;
      if (at_origin) begin
        sh_en_q   <= tgt_en;
        sh_line_q <= tgt_line;
        sh_col_q  <= tgt_col;
      end
      csync_q       <= csync_d;
      vsync_q       <= vsync_d;
      field_out_q   <= field_q;
      burst_q       <= burst_d;
      target_q      <= target_d;
      line_start_q  <= line_start_d;
      field_start_q <= field_start_d;
    end
  end

  assign csync       = csync_q;
  assign vsync       = vsync_q;
  assign field       = field_out_q;
  assign burst       = burst_q;
  assign target      = target_q;
  assign line_start  = line_start_q;
  assign field_start = field_start_q;

endmodule

// File: tb/tb_video_sync_gen.sv
// tb/tb_video_sync_gen.sv - scoreboard bench for video_sync_gen
module tb_video_sync_gen;

  // Shortened fields; horizontal timing kept at its full size
  localparam int L        = 254;
  localparam int HS       = 19;
  localparam int BS       = 21;
  localparam int BW       = 10;
  localparam int F0       = 27;
  localparam int F1       = 26;
  localparam int VS       = 9;
  localparam int TW       = 4;
  localparam int TH       = 4;
  localparam int FRAME    = (F0 + F1) * L;
  localparam int F1_START = F0 * L;

  logic       clk4mhz  = 1'b0;
  logic       reset    = 1'b1;
  logic       tgt_en   = 1'b0;
  logic [8:0] tgt_line = '0;
  logic [8:0] tgt_col  = '0;
  logic       csync, vsync, field, burst, target, line_start, field_start;

  video_sync_gen #(
    .LINE_CLKS(L), .HSYNC_CLKS(HS), .BURST_START(BS), .BURST_CLKS(BW),
    .FIELD0_LINES(F0), .FIELD1_LINES(F1), .VSYNC_LINES(VS), .TGT_W(TW), .TGT_H(TH)
  ) dut (
    .clk4mhz(clk4mhz), .reset(reset), .tgt_en(tgt_en), .tgt_line(tgt_line), .tgt_col(tgt_col),
    .csync(csync), .vsync(vsync), .field(field), .burst(burst), .target(target),
    .line_start(line_start), .field_start(field_start)
  );

  always #5 clk4mhz = ~clk4mhz;

  logic [6:0] exp_q[$];
  int         cyc_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         stim_end = 1'b0;
  int         exp_tgt[16];
  int         exp_lines[16];
  int         tgt_obs[16];
  int         lines_obs[16];
  int         plan_en[16];
  int         plan_line[16];
  int         plan_col[16];

  // Expected {csync,vsync,field,burst,target,line_start,field_start} for frame position pos
  function automatic logic [6:0] model(int pos, int en, int ln, int cl);
    int f, lp, v, h, aline, acol;
    logic [6:0] r;
    f     = (pos >= F1_START) ? 1 : 0;
    lp    = (f == 1) ? pos - F1_START : pos;
    v     = lp / L;
    h     = lp % L;
    aline = v - VS;
    acol  = h - HS;
    r[6]  = (h < HS);
    r[5]  = (v < VS);
    r[4]  = (f == 1);
    r[3]  = (v >= VS) && (h >= BS) && (h < BS + BW);
    r[2]  = (en != 0) && (v >= VS) && (h >= HS) && (aline >= ln) && (aline < ln + TH)
            && (acol >= cl) && (acol < cl + TW);
    r[1]  = (h == 0);
    r[0]  = (h == 0) && (v == 0);
    return r;
  endfunction

  // Target-high cycles in a field of nlines lines, box clipped at line and field end
  function automatic int clip_count(int en, int ln, int cl, int nlines);
    int max_al, max_ac, nl, nc;
    max_al = nlines - VS - 1;
    max_ac = L - HS - 1;
    nl = ((ln + TH - 1 < max_al) ? ln + TH - 1 : max_al) - ln + 1;
    nc = ((cl + TW - 1 < max_ac) ? cl + TW - 1 : max_ac) - cl + 1;
    if (nl < 0) nl = 0;
    if (nc < 0) nc = 0;
    return (en != 0) ? nl * nc : 0;
  endfunction

  task automatic apply_plan(int idx);
    tgt_en   = (plan_en[idx] != 0);
    tgt_line = 9'(plan_line[idx]);
    tgt_col  = 9'(plan_col[idx]);
  endtask

  // Stimulus and reference model: one expected output vector per clock
  initial begin : stim
    int run, fcount, hold, tail, pos, lp, v, h, jl, jh, pl, ph;
    int sh_en, sh_line, sh_col;
    logic [6:0] e;
    plan_en[0] = 1; plan_line[0] = 5;  plan_col[0] = 110;
    plan_en[1] = 1; plan_line[1] = 5;  plan_col[1] = 110;
    plan_en[2] = 1; plan_line[2] = 5;  plan_col[2] = 50;
    plan_en[3] = 1; plan_line[3] = 3;  plan_col[3] = 233;
    plan_en[4] = 1; plan_line[4] = 16; plan_col[4] = 20;
    plan_en[5] = 1; plan_line[5] = 16; plan_col[5] = 20;
    plan_en[6] = 0; plan_line[6] = 5;  plan_col[6] = 110;
    plan_en[8] = 1; plan_line[8] = 0;  plan_col[8] = 0;
    for (int i = 7; i < 16; i++) begin
      if (i != 8) begin
        plan_en[i]   = 1;
        plan_line[i] = int'($urandom_range(0, 20));
        plan_col[i]  = int'($urandom_range(0, 240));
      end
    end
    apply_plan(0);
    run = 0; fcount = -1; hold = 3; tail = -1;
    jl = -1; jh = -1; pl = -1; ph = -1;
    sh_en = 0; sh_line = 0; sh_col = 0;
    for (int c = 0; c < 90000 && tail != 0; c++) begin
      @(posedge clk4mhz);
      v = -1;
      h = -1;
      if (reset) begin
        e = '0;
        run = 0;
        sh_en = 0; sh_line = 0; sh_col = 0;
      end else begin
        pos = run % FRAME;
        lp  = (pos >= F1_START) ? pos - F1_START : pos;
        v   = lp / L;
        h   = lp % L;
        if (lp == 0) begin
          sh_en   = tgt_en ? 1 : 0;
          sh_line = int'(tgt_line);
          sh_col  = int'(tgt_col);
          fcount++;
          if (fcount < 16) begin
            exp_lines[fcount] = (pos == 0) ? F0 : F1;
            exp_tgt[fcount]   = clip_count(sh_en, sh_line, sh_col, exp_lines[fcount]);
          end
          jl = 10 + int'($urandom_range(0, 4));
          jh = int'($urandom_range(0, L - 1));
          pl = 16 + int'($urandom_range(0, 4));
          ph = int'($urandom_range(0, L - 1));
          if (fcount == 10) tail = 300;
        end
        e = model(pos, sh_en, sh_line, sh_col);
        run++;
      end
      exp_q.push_back(e);
      cyc_q.push_back(c);
      #1;
      if (tail > 0) tail--;
      if (hold > 0) begin
        hold--;
        if (hold == 0) reset = 1'b0;
      end
      if (v >= 0 && hold == 0 && fcount >= 0 && fcount < 15) begin
        if (v == jl && h == jh) begin
          tgt_en   = 1'($urandom_range(0, 1));
          tgt_line = 9'($urandom_range(0, 511));
          tgt_col  = 9'($urandom_range(0, 511));
        end
        if (v == pl && h == ph) apply_plan(fcount + 1);
        if (fcount == 7 && v == 20 && h == 99) begin
          reset = 1'b1;
          hold  = 3;
          apply_plan(8);
        end
      end
    end
    stim_end = 1'b1;
    repeat (3) @(negedge clk4mhz);
    for (int i = 0; i < 10; i++) begin
      if (i != 7) begin
        checks++;
        if (tgt_obs[i] != exp_tgt[i]) begin
          errors++;
          $display("FAIL target_count field %0d: got %0d expected %0d", i, tgt_obs[i], exp_tgt[i]);
        end
        checks++;
        if (lines_obs[i] != exp_lines[i]) begin
          errors++;
          $display("FAIL line_count field %0d: got %0d expected %0d", i, lines_obs[i], exp_lines[i]);
        end
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Monitor: compare every output cycle against the scoreboard, gather per-field totals
  int         midx   = -1;
  int         ncyc   = 0;
  int         last_ls = -1;
  logic [6:0] act, expv;
  int         ecyc;
  always @(negedge clk4mhz) begin
    ncyc++;
    act = {csync, vsync, field, burst, target, line_start, field_start};
    if (exp_q.size() > 0) begin
      expv = exp_q.pop_front();
      ecyc = cyc_q.pop_front();
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL outputs cycle %0d: got %b expected %b (csync,vsync,field,burst,target,line_start,field_start)",
                 ecyc, act, expv);
      end
    end else if (!stim_end) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty cycle %0d: got no expected entry, required one", ncyc);
    end
    if (field_start === 1'b1) midx++;
    if (midx >= 0 && midx < 16) begin
      if (target === 1'b1) tgt_obs[midx]++;
      if (line_start === 1'b1) lines_obs[midx]++;
    end
    if (reset) begin
      last_ls = -1;
    end else if (line_start === 1'b1) begin
      if (last_ls >= 0) begin
        checks++;
        if (ncyc - last_ls != L) begin
          errors++;
          $display("FAIL line_period at cycle %0d: got %0d expected %0d", ncyc, ncyc - last_ls, L);
        end
      end
      last_ls = ncyc;
    end
  end

endmodule

// File: doc/video_sync_gen.md
# video_sync_gen

- Generates the composite-video timing the target tracker consumes: `csync`, `vsync`, `field`, `burst`, plus a synthetic target pixel stream (`target`) at a programmable position.
- Sits on the bench or on a spare CPLD as the transmitting end of the sync/video interface. The tracker can be exercised end-to-end without a camera or sync separator.
- Runs from the same 4 MHz pixel clock as the tracker. All outputs are registered.

## Interface
Parameters:
- LINE_CLKS, 254, clocks per line (63.5 µs at 4 MHz)
- HSYNC_CLKS, 19, clocks `csync` is high at the start of each line
- BURST_START, 21, `hcnt` at which `burst` rises
- BURST_CLKS, 10, `burst` width in clocks
- FIELD0_LINES, 263, lines in field 0
- FIELD1_LINES, 262, lines in field 1
- VSYNC_LINES, 9, lines at the start of each field with `vsync` high
- TGT_W, 4, target width in clocks
- TGT_H, 4, target height in lines

Ports:
- clk4mhz  in  1  pixel clock
- reset  in  1  synchronous, active-high
- tgt_en  in  1  target enable
- tgt_line  in  9  target top line, active-line coordinates
- tgt_col  in  9  target left column, active-column coordinates
- csync  out  1  horizontal sync, high = sync pulse
- vsync  out  1  vertical interval, high = vertical sync
- field  out  1  0 = field 0, 1 = field 1
- burst  out  1  burst gate
- target  out  1  synthetic target pixel, high = target
- line_start  out  1  one-cycle strobe at `hcnt == 0`
- field_start  out  1  one-cycle strobe at `hcnt == 0 && vcnt == 0`

## Operation
- **Horizontal counter `hcnt`** (8 bits): counts 0..LINE_CLKS-1, then wraps to 0.
- **Vertical counter `vcnt`** (9 bits):
  - Increments when `hcnt` wraps.
  - Wraps to 0 after FIELD0_LINES-1 when `field_r`=0, or after FIELD1_LINES-1 when `field_r`=1.
  - `field_r` toggles on each `vcnt` wrap.
- **Decodes**, computed from the (`hcnt`, `vcnt`, `field_r`) state and registered:
  - csync = `hcnt` < HSYNC_CLKS
  - vsync = `vcnt` < VSYNC_LINES
  - burst = ~vsync_d && `hcnt` in [BURST_START, BURST_START+BURST_CLKS)
  - field = `field_r`
- **Active coordinates** (10-bit arithmetic, no overflow):
  - acol = `hcnt` − HSYNC_CLKS, valid when `hcnt` ≥ HSYNC_CLKS
  - aline = `vcnt` − VSYNC_LINES, valid when `vcnt` ≥ VSYNC_LINES
- **Target shadow registers:**
  - `tgt_en`, `tgt_line` and `tgt_col` are copied into shadow registers only at `hcnt`==0 && `vcnt`==0.
  - Mid-field input changes never tear the box.
- **`target` output:**
  - High when shadow_en, both coordinates are valid, shadow_line ≤ aline < shadow_line+TGT_H, and shadow_col ≤ acol < shadow_col+TGT_W.
  - Bounds are compared in 10 bits. A box extending past the line end or field end is clipped, not wrapped.

## Timing
- **Reset:**
  - While `reset` is high: `hcnt`=0, `vcnt`=0, `field_r`=0, shadows cleared to 0.
  - All outputs are 0 during reset and in the first cycle after it.
- **Latency:** outputs are registered decodes of the counter state with one cycle of latency.
  - The cycle after counter state (0,0) shows `csync`=1, `vsync`=1, `line_start`=1, `field_start`=1, `field`=0.
- **Shadow load:** occurs in the same cycle as the state (0,0). The new target values first affect `target` in that field.
- **Mid-operation reset:** reset asserted at any point restarts from state (0,0) on the next clock. No partial line or field is completed.
- **Per-line output widths:**
  - `csync` high for exactly HSYNC_CLKS cycles per line.
  - `burst` high for exactly BURST_CLKS cycles on each non-vsync line, 0 on vsync lines.
- **Frame:** 525 lines per frame (263 + 262), `field` alternating 0, 1, 0, …
- **Strobes:** `line_start` and `field_start` are never high for more than one cycle.

## Test plan
- **Reset release, then run 2 lines:**
  - outputs 0 in the first cycle after reset
  - `csync` high 19 cycles, low 235 cycles
  - `line_start` period 254 cycles
- **Run 2 full frames:**
  - `vsync` high for 9 lines per field
  - field 0 spans 263 `line_start` strobes, field 1 spans 262
  - `field` toggles exactly at `field_start`
  - `burst` absent on vsync lines, 10 cycles at `hcnt` 21..30 otherwise
- **`tgt_en`=1, `tgt_line`=100, `tgt_col`=110:**
  - `target` high on aline 100..103, acol 110..113
  - exactly 16 high cycles per field
- **Change `tgt_col` to 50 mid-field (`vcnt`=150):**
  - the current field keeps col 110..113
  - the next field shows 50..53
- **Edge placement:**
  - `tgt_col`=233 yields `target` only at acol 233..234 (2 cycles per line)
  - `tgt_line`=252 in field 1 yields lines 252 only (1 line)
- **Reset asserted at `hcnt`=100, `vcnt`=40, held 3 cycles:**
  - outputs 0 during reset
  - after release, sequence restarts at (0,0) with `field`=0 and `field_start` one cycle later
